// File: rtl/freq_div_monitor.sv
// freq_div_monitor: measures period and high time of a divided clock in
// reference-clock cycles, checks them against the programmed ratio and
// reports results through a valid/ready port with lock, error, stuck and
// overrun status.
module freq_div_monitor #(
  parameter int CW       = 4,
  parameter int TIMEOUT  = 40,
  parameter int LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] mc,
  input  logic          clk_div_in,
  output logic [CW:0]   meas_period,
  output logic [CW:0]   meas_high,
  output logic          meas_valid,
  input  logic          meas_ready,
  output logic          ratio_err,
  output logic          lock,
  output logic          stuck,
  output logic          overrun
);

  localparam int PW = $clog2(TIMEOUT) + 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int MW = (PW > CW + 1) ? PW : CW + 1;
  localparam logic [PW-1:0] PC_MAX   = PW'(TIMEOUT);
  localparam logic [CW:0]   OUT_MAX  = '1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);

  typedef enum logic {
    ST_ARM  = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  logic          r_s1, r_s2, r_s3;
  logic [CW-1:0] r_mc;
  logic [PW-1:0] r_pc;
  logic [CW:0]   r_hc;
  logic          r_stuck;
  state_t        r_state;
  logic [LW-1:0] r_mcnt;
  logic [CW:0]   r_meas_period;
  logic [CW:0]   r_meas_high;
  logic          r_meas_valid;
  logic          r_ratio_err;
  logic          r_lock;
  logic          r_overrun;

  logic          w_rise;
  logic          w_mc_chg;
  logic          w_complete;
  logic [CW:0]   w_n;
  logic [CW:0]   w_half_lo;
  logic [CW:0]   w_half_hi;
  logic [CW:0]   w_period_sat;
  logic          w_match;

  assign w_rise       = r_s2 & ~r_s3;
  assign w_mc_chg     = (r_mc != mc);
  assign w_complete   = w_rise & (r_state == ST_MEAS) & ~w_mc_chg;
  assign w_n          = {1'b0, r_mc} + (CW+1)'(1);
  assign w_half_lo    = w_n >> 1;
  assign w_half_hi    = w_half_lo + {{CW{1'b0}}, w_n[0]};
  // Period counter is wider than the result port; clamp to all-ones.
  assign w_period_sat = (MW'(r_pc) > MW'(OUT_MAX)) ? OUT_MAX : (CW+1)'(r_pc);
  // Odd ratios have a half-cycle duty, so both floor and ceil of N/2 match.
  assign w_match      = (w_period_sat == w_n) &&
                        ((r_hc == w_half_lo) || (r_hc == w_half_hi));

  // Two-flop synchronizer, edge-history flop and registered ratio code
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_mc <= mc;
    end else begin
      r_s1 <= clk_div_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_mc <= mc;
    end
  end

  // Period/high counters restart on each rising edge; stuck flags a silent input
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= '0;
      r_hc    <= '0;
      r_stuck <= 1'b0;
    end else if (w_rise) begin
      r_pc    <= PW'(1);
      r_hc    <= (CW+1)'(1);
      r_stuck <= 1'b0;
    end else begin
      if (r_pc != PC_MAX) begin
        r_pc <= r_pc + PW'(1);
      end
      if (r_s2 && (r_hc != OUT_MAX)) begin
        r_hc <= r_hc + (CW+1)'(1);
      end
      if (r_pc == PC_MAX) begin
        r_stuck <= 1'b1;
      end
    end
  end

  // ARM/MEAS sequencing, match/lock tracking and result handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_ARM;
      r_mcnt        <= '0;
      r_meas_period <= '0;
      r_meas_high   <= '0;
      r_meas_valid  <= 1'b0;
      r_ratio_err   <= 1'b0;
      r_lock        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_mc_chg) begin
        // New ratio: re-arm and forget match history, keep any pending result
        r_state     <= ST_ARM;
        r_mcnt      <= '0;
        r_lock      <= 1'b0;
        r_ratio_err <= 1'b0;
      end else if (w_rise) begin
        case (r_state)
          ST_ARM: r_state <= ST_MEAS;
          ST_MEAS: begin
            if (w_match) begin
              r_ratio_err <= 1'b0;
              if (r_mcnt != LOCK_MAX) begin
                r_mcnt <= r_mcnt + LW'(1);
              end
              if (r_mcnt >= LOCK_MAX - LW'(1)) begin
                r_lock <= 1'b1;
              end
            end else begin
              r_ratio_err <= 1'b1;
              r_mcnt      <= '0;
              r_lock      <= 1'b0;
            end
          end
          default: r_state <= ST_ARM;
        endcase
      end

      if (w_complete) begin
        if (!r_meas_valid || meas_ready) begin
          r_meas_period <= w_period_sat;
          r_meas_high   <= r_hc;
          r_meas_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_meas_valid && meas_ready) begin
        r_meas_valid <= 1'b0;
      end
    end
  end

  assign meas_period = r_meas_period;
  assign meas_high   = r_meas_high;
  assign meas_valid  = r_meas_valid;
  assign ratio_err   = r_ratio_err;
  assign lock        = r_lock;
  assign stuck       = r_stuck;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_freq_div_monitor.sv
// Self-checking bench for freq_div_monitor: a behavioural divider drives the
// monitor; a reference model derives expected results from the sampled
// waveform history (period = distance between sampled rising edges, high
// time = number of high samples in that window).
module tb_freq_div_monitor;
  localparam int CW       = 4;
  localparam int TIMEOUT  = 40;
  localparam int LOCK_CNT = 4;
  localparam int HMAX     = 16384;
  localparam int SATV     = (1 << (CW + 1)) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_div_in = 1'b0;
  logic          meas_ready = 1'b0;
  logic [CW-1:0] mc = 4'd3;
  logic [CW:0]   meas_period, meas_high;
  logic          meas_valid, ratio_err, lock, stuck, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural divider
  int            div_n = 4, div_h = 2, div_ph = 0;
  bit            div_run = 1'b0;
  logic [CW-1:0] mc_drv = 4'd3;

  // reference model state
  int e = 2;
  bit hist [HMAX];
  int m_mc, m_last_rise, m_since, m_mcnt, m_period, m_high;
  bit m_arm, m_valid, m_rerr, m_lock, m_stuck, m_ovr;

  freq_div_monitor #(.CW(CW), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .reset(reset), .mc(mc), .clk_div_in(clk_div_in),
    .meas_period(meas_period), .meas_high(meas_high), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .ratio_err(ratio_err), .lock(lock),
    .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Reference model: advance one clk edge using the inputs present at it
  task automatic model_edge();
    bit rise, chg, comp, ok;
    int p, h, n;
    e++;
    if (e >= HMAX) begin
      $display("FAIL model_history: edge %0d beyond %0d", e, HMAX);
      $fatal(1, "history overflow");
    end
    if (!reset) begin
      hist[e] = 1'b0; hist[e-1] = 1'b0;
      m_mc = int'(mc); m_arm = 1'b1; m_since = 0; m_mcnt = 0;
      m_period = 0; m_high = 0; m_valid = 1'b0; m_rerr = 1'b0;
      m_lock = 1'b0; m_stuck = 1'b0; m_ovr = 1'b0;
      return;
    end
    hist[e] = clk_div_in;
    // a high sample at edge k becomes visible as a rise acted on at edge k+2
    rise = hist[e-2] && !hist[e-3];
    chg  = (int'(mc) != m_mc);
    m_mc = int'(mc);
    comp = rise && !m_arm && !chg;
    if (comp) begin
      p = e - m_last_rise;
      h = 0;
      for (int i = m_last_rise - 2; i <= e - 3; i++) h += int'(hist[i]);
      if (p > SATV) p = SATV;
      if (h > SATV) h = SATV;
      n = m_mc + 1;
      ok = (p == n) && ((h == n / 2) || (h == (n + 1) / 2));
      if (ok) begin
        m_rerr = 1'b0;
        if (m_mcnt < LOCK_CNT) m_mcnt++;
        if (m_mcnt == LOCK_CNT) m_lock = 1'b1;
      end else begin
        m_rerr = 1'b1; m_mcnt = 0; m_lock = 1'b0;
      end
      if (!m_valid || meas_ready) begin
        m_period = p; m_high = h; m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && meas_ready) begin
      m_valid = 1'b0;
    end
    if (chg) begin
      m_arm = 1'b1; m_mcnt = 0; m_lock = 1'b0; m_rerr = 1'b0;
    end else if (rise) begin
      m_arm = 1'b0;
    end
    if (rise) begin
      m_last_rise = e; m_since = 1; m_stuck = 1'b0;
    end else begin
      if (m_since >= TIMEOUT) m_stuck = 1'b1;
      m_since++;
    end
  endtask

  // One clk cycle: drive at negedge, model at posedge, compare just after
  task automatic step(input bit rst_v, input bit rdy_v);
    @(negedge clk);
    reset = rst_v;
    meas_ready = rdy_v;
    mc = mc_drv;
    if (div_run) begin
      clk_div_in = (div_ph < div_h);
      div_ph = (div_ph + 1) % div_n;
    end else begin
      clk_div_in = 1'b0;
      div_ph = 0;
    end
    @(posedge clk);
    model_edge();
    #1;
    check_val("meas_valid",  32'(meas_valid),  32'(m_valid));
    check_val("meas_period", 32'(meas_period), 32'(m_period));
    check_val("meas_high",   32'(meas_high),   32'(m_high));
    check_val("ratio_err",   32'(ratio_err),   32'(m_rerr));
    check_val("lock",        32'(lock),        32'(m_lock));
    check_val("stuck",       32'(stuck),       32'(m_stuck));
    check_val("overrun",     32'(overrun),     32'(m_ovr));
  endtask

  task automatic set_div(input int n, input int h);
    div_n = n; div_h = h; div_ph = 0; div_run = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"},  32'(meas_valid),  0);
    check_val({tag, "_period"}, 32'(meas_period), 0);
    check_val({tag, "_high"},   32'(meas_high),   0);
    check_val({tag, "_err"},    32'(ratio_err),   0);
    check_val({tag, "_lock"},   32'(lock),        0);
    check_val({tag, "_stuck"},  32'(stuck),       0);
    check_val({tag, "_ovr"},    32'(overrun),     0);
  endtask

  initial begin
    int w;
    // reset
    mc_drv = 4'd3;
    repeat (3) step(1'b0, 1'b1);
    check_all_zero("reset");

    // divide by 4
    set_div(4, 2);
    repeat (40) step(1'b1, 1'b1);
    check_val("div4_lock", 32'(lock), 1);
    check_val("div4_period", 32'(meas_period), 4);
    check_val("div4_high", 32'(meas_high), 2);
    check_val("div4_stuck", 32'(stuck), 0);

    // divide by 3, either legal high time
    mc_drv = 4'd2;
    set_div(3, $urandom_range(2, 1));
    repeat (40) step(1'b1, 1'b1);
    check_val("div3_lock", 32'(lock), 1);
    check_val("div3_period", 32'(meas_period), 3);
    check_val("div3_err", 32'(ratio_err), 0);

    // mismatch then correction
    mc_drv = 4'd4;
    set_div(4, 2);
    repeat (40) step(1'b1, 1'b1);
    check_val("mis_err", 32'(ratio_err), 1);
    check_val("mis_lock", 32'(lock), 0);
    check_val("mis_period", 32'(meas_period), 4);
    mc_drv = 4'd3;
    repeat (40) step(1'b1, 1'b1);
    check_val("fix_err", 32'(ratio_err), 0);
    check_val("fix_lock", 32'(lock), 1);

    // backpressure
    step(1'b0, 1'b1);
    set_div(4, 2);
    w = 0;
    while (!meas_valid && w < 40) begin
      step(1'b1, 1'b1);
      w++;
    end
    check_val("bp_first_valid", 32'(meas_valid), 1);
    repeat (12) step(1'b1, 1'b0);
    check_val("bp_overrun", 32'(overrun), 1);
    check_val("bp_held_period", 32'(meas_period), 4);
    step(1'b1, 1'b1);
    check_val("bp_release_drop", 32'(meas_valid), 0);
    repeat (10) step(1'b1, 1'b1);

    // stuck output
    div_run = 1'b0;
    repeat (60) step(1'b1, 1'b1);
    check_val("stuck_set", 32'(stuck), 1);
    set_div(4, 2);
    repeat (20) step(1'b1, 1'b1);
    check_val("stuck_clear", 32'(stuck), 0);

    // reset while locked with a pending result
    repeat (30) step(1'b1, 1'b1);
    w = 0;
    while (!meas_valid && w < 20) begin
      step(1'b1, 1'b0);
      w++;
    end
    check_val("rm_pre_lock", 32'(lock), 1);
    check_val("rm_pre_valid", 32'(meas_valid), 1);
    step(1'b0, 1'b0);
    check_all_zero("rm_reset");
    repeat (20) step(1'b1, 1'b1);

    // randomized segments
    for (int s = 0; s < 30; s++) begin
      int n, h, len;
      n = $urandom_range(16, 2);
      if ($urandom_range(4, 0) == 0) n = $urandom_range(45, 17);
      h = ($urandom_range(1, 0) == 0) ? (n / 2) + int'($urandom_range(1, 0)) * (n % 2)
                                       : $urandom_range(n - 1, 1);
      if (n > 16 || $urandom_range(2, 0) == 0) mc_drv = 4'($urandom_range(15, 1));
      else mc_drv = 4'(n - 1);
      set_div(n, h);
      if ($urandom_range(7, 0) == 0) div_run = 1'b0;
      if ($urandom_range(9, 0) == 0) step(1'b0, 1'b1);
      len = $urandom_range(80, 20);
      for (int c = 0; c < len; c++) begin
        step(1'b1, $urandom_range(3, 0) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_div_monitor.md
# freq_div_monitor

Downstream checker for the programmable frequency divider. It samples the divider's output clock in the `clk` domain and measures each output period and its high time in `clk` cycles. It compares each measurement with the programmed ratio and hands results out through a valid/ready port. It also reports lock, ratio errors, stuck output and result overrun, so the divider can be checked in-system and in benches without a scope.

## Interface
- `CW`, 4: width of the ratio code `mc`. Programmed divide ratio N = `mc`+1.
- `TIMEOUT`, 40: `clk` cycles without an output rising edge before `stuck` asserts.
- `LOCK_CNT`, 4: number of consecutive matching periods required for `lock`.

- `clk`, in, 1: reference clock; drives the divider and this block.
- `reset`, in, 1: synchronous, active-low reset. Sampled on `clk` rising edge.
- `mc`, in, CW: ratio code, the same value fed to the divider.
- `clk_div_in`, in, 1: divider output `clk_out`. Asynchronous to `clk` sampling because it may change on the `clk` falling edge.
- `meas_period`, out, CW+1: last measured period in `clk` cycles. Saturates at all-ones.
- `meas_high`, out, CW+1: sampled high cycles in that period. Saturates at all-ones.
- `meas_valid`, out, 1: result is available.
- `meas_ready`, in, 1: consumer accepts the result.
- `ratio_err`, out, 1: registered; describes the last completed period.
- `lock`, out, 1: LOCK_CNT consecutive periods have matched.
- `stuck`, out, 1: no output rising edge for TIMEOUT cycles.
- `overrun`, out, 1: sticky; a result was dropped because of backpressure.

## Operation
- Input path: two-flop synchronizer `s1`→`s2`, plus history flop `s3`. Rising edge condition: `rise` = `s2` & ~`s3`.
- FSM, two states:
  - ARM (entered from reset and on any `mc` change): wait for `rise`, then go to MEAS. No results are produced in ARM.
  - MEAS: on each `rise`, complete a measurement and restart the counters.
- Period counter `pc`, width log2(TIMEOUT)+1:
  - Loaded with 1 on `rise`; otherwise increments, saturating at TIMEOUT.
- High counter `hc`:
  - Loaded with 1 on `rise`.
  - Otherwise increments when `s2`=1, saturating at all-ones.
- Measurement completion (`rise` while in MEAS):
  - `meas_period` ← min(`pc`, 2^(CW+1)-1).
  - `meas_high` ← saturated `hc`.
- Match rule:
  - Period must equal N.
  - High time must be floor(N/2) or ceil(N/2). Odd N gives half-cycle duty, so either value is legal.
- On a matching completion:
  - `ratio_err` ← 0.
  - Consecutive-match count increments, saturating at LOCK_CNT.
  - `lock` ← 1 when the count reaches LOCK_CNT.
- On a mismatching completion:
  - `ratio_err` ← 1.
  - Match count ← 0; `lock` ← 0.
- Handshake:
  - On completion with `meas_valid`=0, or with `meas_valid`=1 and `meas_ready`=1: load the result and set `meas_valid`=1.
  - On completion with `meas_valid`=1 and `meas_ready`=0: keep the old result, set `overrun`=1, and still update `ratio_err` and `lock`.
  - `meas_valid` clears on `meas_valid` & `meas_ready` when no completion occurs in the same cycle.
  - Output data is stable while `meas_valid`=1 and `meas_ready`=0.
- Stuck detection:
  - `stuck` ← 1 when `pc` reaches TIMEOUT, in either state (`pc` keeps counting in ARM).
  - `stuck` clears on the next `rise`.
- `mc` change (registered copy differs from input):
  - Go to ARM, clear match count and `lock`, clear `ratio_err`.
  - A pending `meas_valid` result is kept.
- Supported range is `mc` ≥ 1. With `mc`=0 (N=1) no edges are sampled, so `stuck` asserts after TIMEOUT cycles.

## Timing
- Reset (`reset`=0 at a `clk` edge) sets, in the next cycle:
  - Outputs `meas_period`=0, `meas_high`=0, `meas_valid`=0, `ratio_err`=0, `lock`=0, `stuck`=0, `overrun`=0.
  - Internals: synchronizer flops 0, `pc`=0, `hc`=0, FSM in ARM.
- Reset mid-measurement discards all state, including a pending result.
- Latency: `clk_div_in` high sampled at edge k → `rise` during cycle k+2 → results, `meas_valid`, `ratio_err` and `lock` visible after edge k+2.
- Steady state with divide ratio N: one completion every N cycles.
- The first result arrives on the second `rise` after ARM.
- `lock` first rises on completion number LOCK_CNT in MEAS.
- The synchronizer path is the only place `clk_div_in` is used.

## Test plan
- Divide by 4: `mc`=3 to both divider and monitor, `meas_ready`=1. Required: every result `meas_period`=4, `meas_high`=2, `ratio_err`=0; `lock`=1 after the 4th result; `stuck`=0.
- Divide by 3: `mc`=2. Required: `meas_period`=3, `meas_high` ∈ {1,2}, `ratio_err`=0, `lock`=1 after 4 results.
- Mismatch: divider runs N=4, monitor `mc`=4. Required: `meas_period`=4, `ratio_err`=1, `lock` stays 0. Then set the monitor to `mc`=3: re-arm, and the following results have `ratio_err`=0.
- Backpressure: divide by 4, `meas_ready`=0 for 12 cycles after the first `meas_valid`. Required: first result held stable, `overrun`=1. Releasing `meas_ready` for one cycle drops `meas_valid` until the next completion.
- Stuck: hold `clk_div_in`=0. Required: `stuck`=1 exactly TIMEOUT=40 cycles after the last `rise`. Restarting the divider clears `stuck` on the first `rise`.
- Reset mid-operation: `reset`=0 for one cycle while locked with `meas_valid`=1. Required: all outputs 0 the next cycle; first new result 2 output periods later.
